// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if: roll/turn handshake and target-position bus between game logic and renderer
interface turn_sequencer_if;
  logic       roll_req;
  logic       dice_force_en;
  logic [2:0] dice_force_val;
  logic       turn_done;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic [2:0] dice_value;
  logic       game_over;
  logic       winner;
  modport master (
    input  roll_req, dice_force_en, dice_force_val, turn_done,
    output player1_pos_x, player2_pos_x, pos_valid, active_player, dice_value, game_over, winner
  );
  modport slave (
    output roll_req, dice_force_en, dice_force_val, turn_done,
    input  player1_pos_x, player2_pos_x, pos_valid, active_player, dice_value, game_over, winner
  );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer: two-player board-game turn FSM with die LFSR, clamped moves, question-box bonus and win detect
module turn_sequencer #(
  parameter int         TILE_X0      = 20,
  parameter int         TILE_PITCH   = 60,
  parameter int         LAST_TILE    = 10,
  parameter int         QBOX_TILE    = 4,
  parameter int         QBOX_BONUS   = 2,
  parameter logic [7:0] LFSR_SEED    = 8'hA5,
  parameter int         TURN_TIMEOUT = 25_000_000
) (
  input logic              clk,
  input logic              rst,
  turn_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, ROLL, MOVE, WAIT_DONE, CHECK, NEXT, OVER} state_t;
  state_t      state, nstate;
  logic [7:0]  lfsr, tile1, tile2, cur_tile, sum, new_tile;
  logic [9:0]  x1, x2, new_x;
  logic [2:0]  dice, die;
  logic [31:0] cnt;
  logic        act, bonus, at_goal, take_bonus, timed_out, load;
  assign die        = bus.dice_force_en ? bus.dice_force_val : 3'(lfsr % 8'd6) + 3'd1;
  assign cur_tile   = act ? tile2 : tile1;
  assign sum        = cur_tile + (state == ROLL ? {5'd0, die} : 8'(QBOX_BONUS));
  assign new_tile   = sum > 8'(LAST_TILE) ? 8'(LAST_TILE) : sum;
  assign new_x      = 10'(TILE_X0 + TILE_PITCH * int'(new_tile));
  assign at_goal    = cur_tile == 8'(LAST_TILE);
  assign take_bonus = cur_tile == 8'(QBOX_TILE) && !bonus && !at_goal;
  assign timed_out  = (TURN_TIMEOUT != 0) && (cnt + 32'd1 >= 32'(TURN_TIMEOUT));
  // Position registers load on the edge into MOVE so they coincide with pos_valid
  assign load       = state == ROLL || (state == CHECK && take_bonus);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end
  always_comb begin
    nstate = state;
    case (state)
      IDLE:      nstate = bus.roll_req ? ROLL : IDLE;
      ROLL:      nstate = MOVE;
      MOVE:      nstate = WAIT_DONE;
      WAIT_DONE: nstate = (bus.turn_done || timed_out) ? CHECK : WAIT_DONE;
      CHECK:     nstate = at_goal ? OVER : take_bonus ? MOVE : NEXT;
      NEXT:      nstate = IDLE;
      OVER:      nstate = OVER;
      default:   nstate = IDLE;
    endcase
  end
  always_comb begin
    bus.pos_valid = state == MOVE;
    bus.game_over = state == OVER;
    bus.winner    = state == OVER && act;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr  <= LFSR_SEED;
      tile1 <= '0;
      tile2 <= '0;
      x1    <= 10'(TILE_X0);
      x2    <= 10'(TILE_X0);
      dice  <= '0;
      act   <= 1'b0;
      bonus <= 1'b0;
      cnt   <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (load && act) begin
        tile2 <= new_tile;
        x2    <= new_x;
      end
      if (load && !act) begin
        tile1 <= new_tile;
        x1    <= new_x;
      end
      if (state == ROLL) dice <= die;
      if (state == CHECK && take_bonus) bonus <= 1'b1;
      if (state == CHECK && nstate == NEXT) begin
        act   <= ~act;
        bonus <= 1'b0;
      end
      cnt <= state == MOVE ? '0 : state == WAIT_DONE ? cnt + 32'd1 : cnt;
    end
  end
  assign bus.player1_pos_x = x1;
  assign bus.player2_pos_x = x2;
  assign bus.active_player = act;
  assign bus.dice_value    = dice;
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed checks of rolls, bonus, clamping, win, timeout, reset and the free-running die
module tb_turn_sequencer;
  logic clk = 0, rst = 1;
  int   errors = 0, checks = 0;
  turn_sequencer_if bus();
  turn_sequencer #(.TURN_TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic roll(input logic [2:0] v, input logic force_en);
    bus.dice_force_en  = force_en;
    bus.dice_force_val = v;
    bus.roll_req = 1;
    tick();
    bus.roll_req = 0;
    chk("roll_lat1", bus.pos_valid, 0);
    tick();
  endtask
  task automatic done();
    bus.turn_done = 1;
    tick();
    bus.turn_done = 0;
  endtask
  int pv_seen;
  logic [7:0] seen;
  initial begin
    bus.roll_req = 0; bus.turn_done = 0; bus.dice_force_en = 1; bus.dice_force_val = 3'd1;
    tick(); tick();
    rst = 0;
    chk("rst_p1", bus.player1_pos_x, 20);
    chk("rst_p2", bus.player2_pos_x, 20);
    chk("rst_pv", bus.pos_valid, 0);
    chk("rst_ap", bus.active_player, 0);
    chk("rst_dv", bus.dice_value, 0);
    chk("rst_go", bus.game_over, 0);
    roll(3'd3, 1);
    chk("t1_pv", bus.pos_valid, 1);
    chk("t1_p1", bus.player1_pos_x, 200);
    chk("t1_p2", bus.player2_pos_x, 20);
    chk("t1_dv", bus.dice_value, 3);
    tick();
    chk("t1_pv_off", bus.pos_valid, 0);
    done();
    chk("t1_ap_check", bus.active_player, 0);
    tick();
    chk("t1_ap_next", bus.active_player, 1);
    tick();
    bus.turn_done = 1; tick(); bus.turn_done = 0; tick();
    chk("idle_stray_ap", bus.active_player, 1);
    chk("idle_stray_pv", bus.pos_valid, 0);
    roll(3'd4, 1);
    chk("t2_pv", bus.pos_valid, 1);
    chk("t2_p2", bus.player2_pos_x, 260);
    chk("t2_p1", bus.player1_pos_x, 200);
    tick();
    done();
    chk("t2_check_pv", bus.pos_valid, 0);
    tick();
    chk("t2_bonus_pv", bus.pos_valid, 1);
    chk("t2_bonus_p2", bus.player2_pos_x, 380);
    chk("t2_bonus_ap", bus.active_player, 1);
    tick();
    bus.roll_req = 1; tick(); bus.roll_req = 0;
    pv_seen = 0;
    repeat (3) begin tick(); pv_seen |= int'(bus.pos_valid); end
    chk("wait_stray_pv", pv_seen, 0);
    chk("wait_stray_dv", bus.dice_value, 4);
    done(); tick();
    chk("t2_ap_next", bus.active_player, 0);
    tick();
    roll(3'd2, 1);
    chk("to_p1", bus.player1_pos_x, 320);
    repeat (14) tick();
    chk("to_ap_early", bus.active_player, 0);
    repeat (6) tick();
    chk("to_ap_late", bus.active_player, 1);
    roll(3'd5, 1);
    chk("win_p2", bus.player2_pos_x, 620);
    chk("win_dv", bus.dice_value, 5);
    tick();
    done(); tick();
    chk("win_go", bus.game_over, 1);
    chk("win_who", bus.winner, 1);
    pv_seen = 0;
    bus.roll_req = 1; tick(); bus.roll_req = 0; pv_seen |= int'(bus.pos_valid);
    bus.turn_done = 1; tick(); bus.turn_done = 0; pv_seen |= int'(bus.pos_valid);
    repeat (4) begin tick(); pv_seen |= int'(bus.pos_valid); end
    chk("over_pv", pv_seen, 0);
    chk("over_ap", bus.active_player, 1);
    chk("over_go", bus.game_over, 1);
    rst = 1; tick(); rst = 0;
    roll(3'd6, 1);
    chk("r_p1", bus.player1_pos_x, 380);
    tick(); tick();
    rst = 1; tick(); rst = 0;
    chk("rw_p1", bus.player1_pos_x, 20);
    chk("rw_p2", bus.player2_pos_x, 20);
    chk("rw_ap", bus.active_player, 0);
    chk("rw_dv", bus.dice_value, 0);
    chk("rw_pv", bus.pos_valid, 0);
    chk("rw_go", bus.game_over, 0);
    roll(3'd2, 1);
    chk("rw_roll_pv", bus.pos_valid, 1);
    chk("rw_roll_p1", bus.player1_pos_x, 140);
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      rst = 1; tick(); rst = 0;
      repeat (i) tick();
      roll(3'd0, 0);
      chk("free_range", int'(bus.dice_value >= 3'd1 && bus.dice_value <= 3'd6), 1);
      seen[bus.dice_value] = 1'b1;
    end
    chk("free_distinct", int'($countones(seen) >= 3), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-logic stage directly upstream of the VGA UI renderer.
- Runs the two-player turn-based board game: accepts a roll request, generates a die value 1..6, and advances the active player's tile with clamping.
- Applies the question-box bonus and detects a win.
- Publishes target pixel x-positions with a one-cycle pos_valid pulse, then waits for the renderer's turn_done before handing the turn to the other player.

Parameters:
- TILE_X0, 20, pixel x of tile 0
- TILE_PITCH, 60, pixel distance between tiles
- LAST_TILE, 10, goal tile index; landing on it wins
- QBOX_TILE, 4, question-box tile index
- QBOX_BONUS, 2, extra tiles granted on landing exactly on QBOX_TILE
- LFSR_SEED, 8'hA5, reset value of the die LFSR; must be non-zero
- TURN_TIMEOUT, 25_000_000, cycles to wait for turn_done before proceeding; 0 = wait forever

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst  in  1  synchronous, active-high reset
- roll_req  in  1  one-cycle roll request (debounced button); honoured only in IDLE
- dice_force_en  in  1  when 1, the die value is taken from dice_force_val instead of the LFSR
- dice_force_val  in  3  forced die value; legal range 1..6
- turn_done  in  1  one-cycle pulse from the renderer: movement animation finished
- player1_pos_x  out  10  Player 1 target pixel x
- player2_pos_x  out  10  Player 2 target pixel x
- pos_valid  out  1  one-cycle pulse: target positions updated
- active_player  out  1  0 = Player 1, 1 = Player 2
- dice_value  out  3  last rolled value (0 after reset)
- game_over  out  1  high once a player reaches LAST_TILE
- winner  out  1  winning player; valid only while game_over = 1

Behaviour:
- Interface decision: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - both tile registers 0
  - player1_pos_x = player2_pos_x = TILE_X0
  - pos_valid = 0, active_player = 0, dice_value = 0
  - game_over = 0, winner = 0
  - LFSR = LFSR_SEED, timeout counter = 0, state = IDLE
- rst asserted in any state, including mid-wait, returns everything to reset values on the next edge. No pos_valid is generated by reset.
- Die LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; steps every cycle regardless of state.
  - Die value = (lfsr mod 6) + 1, giving range 1..6.
- pos_x = TILE_X0 + tile*TILE_PITCH, computed in 10 bits. The defaults give a maximum of 620.
- FSM states:
  - IDLE: wait for roll_req. roll_req in any other state is ignored.
  - ROLL: capture the die value (forced or LFSR) into dice_value. new_tile = min(tile[active] + dice, LAST_TILE). Go to MOVE.
  - MOVE: write new_tile; update only the active player's pos_x; assert pos_valid for exactly this one cycle. Clear the timeout counter. Go to WAIT_DONE.
  - WAIT_DONE: on turn_done, or when the counter reaches TURN_TIMEOUT (if non-zero), go to CHECK. turn_done pulses in any other state are ignored.
  - CHECK, evaluated in priority order:
    - (a) tile == LAST_TILE: go to OVER.
    - (b) tile == QBOX_TILE and bonus not yet used this turn: set the bonus flag; new_tile = min(tile + QBOX_BONUS, LAST_TILE); go to MOVE. The same player keeps the turn; this produces a second pos_valid pulse.
    - (c) otherwise: go to NEXT.
  - NEXT: toggle active_player, clear the bonus flag, go to IDLE.
  - OVER: game_over = 1, winner = active_player. Terminal; active_player frozen; only rst exits.
- Latency:
  - roll_req sampled in IDLE → pos_valid high exactly 2 cycles later (IDLE → ROLL → MOVE).
  - turn_done → active_player toggles 2 cycles later (CHECK → NEXT) when no bonus or win applies.
- Stability:
  - pos_x outputs change only in the MOVE cycle and are stable at all other times.
  - The inactive player's pos_x never changes during the other player's turn.
  - Overshoot is clamped: exact landing on LAST_TILE is not required.
  - A bonus landing never re-triggers the bonus within the same turn.

Test Plan:
- Reset, then force die = 3, pulse roll_req → pos_valid pulses 2 cycles later, player1_pos_x = 200, player2_pos_x = 20. After turn_done, active_player = 1 within 2 cycles.
- Player 1 at tile 0, force die = 4 → pos_valid with x = 260. After turn_done, a second pos_valid with x = 380 (tile 6); active_player stays 0 until the second turn_done, then toggles to 1.
- Player at tile 8, force die = 5 → clamped to tile 10, x = 620. After turn_done: game_over = 1, winner = active player. Further roll_req or turn_done pulses produce no pos_valid.
- roll_req and stray turn_done pulses issued during WAIT_DONE and IDLE respectively → no state change, no extra pos_valid, dice_value unchanged.
- TURN_TIMEOUT set to 16, turn_done withheld → the FSM reaches CHECK after 16 cycles and active_player toggles.
- rst asserted in WAIT_DONE → next cycle: both pos_x = 20, active_player = 0, dice_value = 0, pos_valid = 0. A subsequent roll works normally.
- Unforced: 64 consecutive rolls → every dice_value is within 1..6 and at least 3 distinct values appear.
